// File: rtl/max_finder_ctrl.sv
// ---------------------------------------------------------------------------
// max_finder_ctrl
//
// Purpose:
//   Control FSM that scans a frame of N samples and reports the largest value
//   and its 0-based position in the frame. The magnitude comparison itself is
//   done by a shared, external greater_than block: this controller drives its
//   operands (o_gt_a / o_gt_b) and reads back the result (i_gt_f) in the
//   same cycle.
//
// Parameters:
//   N  samples per frame, 1..16
//   W  sample width, must match the shared greater_than datapath
//
// Ports:
//   i_clk       single clock, rising edge
//   i_rst       synchronous, active-high reset
//   i_start     single-cycle request to begin a frame (ignored while busy)
//   i_in_valid  sample present on i_in_data
//   i_in_data   sample value
//   o_in_ready  controller accepts a sample this cycle
//   o_gt_a      A operand to greater_than (held sample during CMP, else 0)
//   o_gt_b      B operand to greater_than (current max during CMP, else 0)
//   i_gt_f      greater_than result, 1 when o_gt_a > o_gt_b
//   o_busy      frame in progress
//   o_done      one-cycle pulse, frame result is final
//   o_max_val   largest sample of the last completed frame
//   o_max_idx   frame position of o_max_val
//
// Configuration:
//   MAX_FINDER_TIE_LAST_EN  when defined, an equal sample replaces the current
//                           max so the last of several equal maxima wins;
//                           when undefined the first one wins.
// ---------------------------------------------------------------------------
module max_finder_ctrl #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_in_valid,
  input  logic [W-1:0] i_in_data,
  output logic         o_in_ready,
  output logic [W-1:0] o_gt_a,
  output logic [W-1:0] o_gt_b,
  input  logic         i_gt_f,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_max_val,
  output logic [3:0]   o_max_idx
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Frame length widened to 5 bits so that N = 16 can be compared against
  // cnt+1 without overflow.
  localparam logic [4:0] LP_N = 5'(N);

  state_t       r_state;
  logic [3:0]   r_cnt;
  logic [W-1:0] r_hold;
  logic [W-1:0] r_max_val;
  logic [3:0]   r_max_idx;
  logic         r_in_ready;
  logic         r_busy;
  logic         r_done;
  logic [W-1:0] r_gt_a;
  logic [W-1:0] r_gt_b;

  logic         w_accept;
  logic         w_update;
  logic [4:0]   w_cnt_inc;
  logic         w_last;

  // A sample is consumed only in LOAD with both sides of the handshake high.
  assign w_accept  = (r_state == LOAD) && i_in_valid && r_in_ready;

  // cnt+1 reaching N marks the final sample of the frame. The counter itself
  // is never advanced past N-1; the FSM moves to DONE instead.
  assign w_cnt_inc = {1'b0, r_cnt} + 5'd1;
  assign w_last    = (w_cnt_inc == LP_N);

  // Decides whether the held sample replaces the current max during CMP.
  // r_hold is compared directly for the tie case so the external comparator
  // only ever has to answer "strictly greater".
`ifdef MAX_FINDER_TIE_LAST_EN
  assign w_update = i_gt_f || (r_hold == r_max_val);
`else
  assign w_update = i_gt_f;
`endif

  // Main FSM. Every output is a register updated alongside the state so the
  // outputs are glitch-free: in_ready is raised on entry to LOAD, the
  // comparator operands are loaded on entry to CMP and cleared on exit, and
  // done is raised on entry to DONE and dropped on the way back to IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_hold     <= '0;
      r_max_val  <= '0;
      r_max_idx  <= 4'd0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_gt_a     <= '0;
      r_gt_b     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state    <= LOAD;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_cnt      <= 4'd0;
            r_hold     <= '0;
            r_max_val  <= '0;
            r_max_idx  <= 4'd0;
          end
        end

        LOAD: begin
          if (w_accept) begin
            if (r_cnt == 4'd0) begin
              // First sample seeds the running max without a comparison.
              r_max_val <= i_in_data;
              r_max_idx <= 4'd0;
              if (w_last) begin
                r_state    <= DONE;
                r_in_ready <= 1'b0;
                r_done     <= 1'b1;
              end else begin
                r_cnt <= r_cnt + 4'd1;
              end
            end else begin
              r_hold     <= i_in_data;
              r_gt_a     <= i_in_data;
              r_gt_b     <= r_max_val;
              r_in_ready <= 1'b0;
              r_state    <= CMP;
            end
          end
        end

        CMP: begin
          if (w_update) begin
            r_max_val <= r_hold;
            r_max_idx <= r_cnt;
          end
          r_gt_a <= '0;
          r_gt_b <= '0;
          if (w_last) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt      <= r_cnt + 4'd1;
            r_in_ready <= 1'b1;
            r_state    <= LOAD;
          end
        end

        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state    <= IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_gt_a     <= '0;
          r_gt_b     <= '0;
        end
      endcase
    end
  end

  assign o_in_ready = r_in_ready;
  assign o_gt_a     = r_gt_a;
  assign o_gt_b     = r_gt_b;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_max_val  = r_max_val;
  assign o_max_idx  = r_max_idx;

endmodule

// File: tb/tb_max_finder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_max_finder_ctrl
//
// Self-checking bench for max_finder_ctrl with N=4, W=2. A behavioural
// comparator stands in for the shared greater_than block. Expected frame
// results come from a reference model that finds the maximum value of the
// frame and then picks its first (or, with MAX_FINDER_TIE_LAST_EN, last)
// occurrence.
// ---------------------------------------------------------------------------
module tb_max_finder_ctrl;

  localparam int N = 4;
  localparam int W = 2;

`ifdef MAX_FINDER_TIE_LAST_EN
  localparam bit TIE_LAST = 1'b1;
`else
  localparam bit TIE_LAST = 1'b0;
`endif

  typedef logic [W-1:0] frame_t [N];

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         inValid;
  logic [W-1:0] inData;
  logic         inReady;
  logic [W-1:0] gtA;
  logic [W-1:0] gtB;
  logic         gtF;
  logic         busy;
  logic         done;
  logic [W-1:0] maxVal;
  logic [3:0]   maxIdx;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;
  int startCycle  = 0;
  int doneSeen    = 0;

  max_finder_ctrl #(.N(N), .W(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_in_valid (inValid),
    .i_in_data  (inData),
    .o_in_ready (inReady),
    .o_gt_a     (gtA),
    .o_gt_b     (gtB),
    .i_gt_f     (gtF),
    .o_busy     (busy),
    .o_done     (done),
    .o_max_val  (maxVal),
    .o_max_idx  (maxIdx)
  );

  // Behavioural stand-in for the shared greater_than instance.
  assign gtF = (gtA > gtB);

  always #5 clk = ~clk;

  // Counts done pulses independently of the directed steps so that missing
  // or duplicated pulses are caught.
  always @(negedge clk) begin
    if (done === 1'b1) doneSeen++;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cycleCount++;
  endtask

  // Reference: largest value first, then its first or last position.
  task automatic refModel(input frame_t s, output logic [W-1:0] mv, output logic [3:0] mi);
    int best;
    int pos;
    best = 0;
    for (int i = 0; i < N; i++) if (int'(s[i]) > best) best = int'(s[i]);
    pos = -1;
    for (int i = 0; i < N; i++) begin
      if (int'(s[i]) == best && (pos < 0 || TIE_LAST)) pos = i;
    end
    mv = W'(best);
    mi = 4'(pos);
  endtask

  task automatic startFrame();
    start = 1'b1;
    startCycle = cycleCount;
    tick();
    start = 1'b0;
    checkOutput("start_busy", busy, 1);
    checkOutput("start_ready", inReady, 1);
    checkOutput("start_clr_val", maxVal, 0);
    checkOutput("start_clr_idx", maxIdx, 0);
  endtask

  // Drives one sample: optional idle gap, then holds it valid until the
  // handshake completes. For non-first samples the cycle right after
  // acceptance is the comparison cycle, whose operands are checked.
  task automatic feedSample(input logic [W-1:0] d, input int k, input int gap,
                            input bit pokeStart, input logic [W-1:0] runMax);
    int t;
    for (int g = 0; g < gap; g++) begin
      inValid = 1'b0;
      inData  = 2'($urandom_range(0, 3));
      tick();
    end
    inValid = 1'b1;
    inData  = d;
    start   = pokeStart;
    t = 0;
    while (inReady !== 1'b1 && t < 16) begin
      tick();
      t++;
    end
    checkOutput("ready_wait", inReady, 1);
    tick();
    inValid = 1'b0;
    start   = 1'b0;
    if (k > 0) begin
      checkOutput("cmp_ready", inReady, 0);
      checkOutput("cmp_gt_a", gtA, d);
      checkOutput("cmp_gt_b", gtB, runMax);
    end else begin
      checkOutput("first_ready", inReady, 1);
    end
  endtask

  task automatic applyStimulus(input frame_t s, input int gap, input bit extraStart);
    logic [W-1:0] expMax;
    logic [3:0]   expIdx;
    logic [W-1:0] runMax;
    int           doneBefore;
    int           t;
    refModel(s, expMax, expIdx);
    doneBefore = doneSeen;
    startFrame();
    runMax = s[0];
    for (int k = 0; k < N; k++) begin
      feedSample(s[k], k, gap, extraStart && (k == 2), runMax);
      if (s[k] > runMax) runMax = s[k];
    end
    t = 0;
    while (done !== 1'b1 && t < 8) begin
      tick();
      t++;
    end
    checkOutput("done_seen", done, 1);
    if (gap == 0) checkOutput("latency", cycleCount - startCycle, 2 * N);
    checkOutput("done_max_val", maxVal, expMax);
    checkOutput("done_max_idx", maxIdx, expIdx);
    checkOutput("done_busy", busy, 1);
    checkOutput("done_gt_a", gtA, 0);
    tick();
    checkOutput("post_busy", busy, 0);
    checkOutput("post_done", done, 0);
    checkOutput("post_ready", inReady, 0);
    checkOutput("post_gt_b", gtB, 0);
    checkOutput("hold_max_val", maxVal, expMax);
    checkOutput("hold_max_idx", maxIdx, expIdx);
    checkOutput("done_count", doneSeen - doneBefore, 1);
  endtask

  initial begin
    frame_t f;
    int     doneBefore;

    rst     = 1'b1;
    start   = 1'b0;
    inValid = 1'b0;
    inData  = '0;
    tick();
    tick();
    $display("[TB] checking reset state");
    checkOutput("rst_ready", inReady, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_gt_a", gtA, 0);
    checkOutput("rst_gt_b", gtB, 0);
    checkOutput("rst_max_val", maxVal, 0);
    checkOutput("rst_max_idx", maxIdx, 0);
    rst = 1'b0;
    tick();

    // Input valid while idle must not start or consume anything.
    inValid = 1'b1;
    inData  = 2'd3;
    tick();
    inValid = 1'b0;
    checkOutput("idle_valid_busy", busy, 0);

    $display("[TB] frame 1,3,2,0");
    f = '{2'd1, 2'd3, 2'd2, 2'd0};
    applyStimulus(f, 0, 1'b0);

    $display("[TB] frame 2,2,1,2 (tie handling)");
    f = '{2'd2, 2'd2, 2'd1, 2'd2};
    applyStimulus(f, 0, 1'b0);

    $display("[TB] frame 0,0,0,3 continuous valid");
    f = '{2'd0, 2'd0, 2'd0, 2'd3};
    applyStimulus(f, 0, 1'b0);

    $display("[TB] frame 3,1,1,1 with start while busy");
    f = '{2'd3, 2'd1, 2'd1, 2'd1};
    applyStimulus(f, 0, 1'b1);

    $display("[TB] reset mid-frame");
    doneBefore = doneSeen;
    startFrame();
    feedSample(2'd2, 0, 0, 1'b0, 2'd0);
    feedSample(2'd3, 1, 0, 1'b0, 2'd2);
    rst     = 1'b1;
    start   = 1'b1;
    inValid = 1'b1;
    inData  = 2'd1;
    tick();
    rst     = 1'b0;
    start   = 1'b0;
    inValid = 1'b0;
    checkOutput("mid_rst_ready", inReady, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_gt_a", gtA, 0);
    checkOutput("mid_rst_gt_b", gtB, 0);
    checkOutput("mid_rst_max_val", maxVal, 0);
    checkOutput("mid_rst_max_idx", maxIdx, 0);
    repeat (4) tick();
    checkOutput("mid_rst_idle_busy", busy, 0);
    checkOutput("mid_rst_no_done", doneSeen - doneBefore, 0);
    f = '{2'd1, 2'd0, 2'd0, 2'd2};
    applyStimulus(f, 0, 1'b0);

    $display("[TB] frame 0,1,2,3 with 3-cycle gaps");
    f = '{2'd0, 2'd1, 2'd2, 2'd3};
    applyStimulus(f, 3, 1'b0);

    $display("[TB] random frames");
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < N; i++) f[i] = 2'($urandom_range(0, 3));
      applyStimulus(f, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/max_finder_ctrl.md
MAX_FINDER_CTRL -- requirements
Module: max_finder_ctrl

Interface
REQ-001 Parameter N, default 4: samples per frame, legal range 1..16.
REQ-002 Parameter W, default 2: sample width, matching the shared greater_than datapath.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a frame.
REQ-006 in_valid  input  1  sample present on in_data.
REQ-007 in_data  input  W  sample value.
REQ-008 in_ready  output  1  controller can accept a sample this cycle.
REQ-009 gt_a  output  W  A operand driven to the external greater_than instance.
REQ-010 gt_b  output  W  B operand driven to the external greater_than instance.
REQ-011 gt_f  input  1  comparator result, 1 when gt_a > gt_b (combinational, same cycle).
REQ-012 busy  output  1  a frame is in progress.
REQ-013 done  output  1  one-cycle pulse marking that the frame result is final.
REQ-014 max_val  output  W  largest sample of the last completed frame.
REQ-015 max_idx  output  4  0-based frame position of max_val.

Function
REQ-016 The FSM SHALL have four states: IDLE, LOAD, CMP and DONE.
REQ-017 IDLE: start=1 SHALL transition to LOAD; clear the sample counter; clear max_val/max_idx.
REQ-018 LOAD: in_ready SHALL be 1; a sample is accepted only when in_valid && in_ready.
REQ-019 LOAD, first accepted sample (cnt=0): store it as the current max with idx 0; cnt+1.
- If N=1, go to DONE; otherwise stay in LOAD.
REQ-020 LOAD, later accepted sample: latch it into a hold register; go to CMP.
REQ-021 CMP: in_ready=0, gt_a=hold, gt_b=current max.
- If gt_f=1, current max SHALL become hold and idx SHALL become cnt.
- Then cnt+1.
- If cnt+1=N, go to DONE; otherwise go to LOAD.
REQ-022 Ties (equal values) SHALL keep the earlier index unless TIE_LAST_EN is defined.
REQ-023 DONE: done=1 for exactly one cycle; max_val/max_idx hold the final result; go to IDLE.
REQ-024 busy SHALL be 1 in LOAD, CMP and DONE, and 0 in IDLE.
REQ-025 start while busy=1 SHALL be ignored.
REQ-026 in_valid outside LOAD SHALL be ignored; no sample is consumed.
REQ-027 Throughput: 2 cycles per sample after the first, given continuous in_valid.
REQ-028 Latency: done SHALL assert 1 cycle after the CMP of the final sample.
REQ-029 gt_a/gt_b SHALL be 0 outside CMP.
REQ-030 max_val/max_idx SHALL hold their values after DONE until the next start.
REQ-031 cnt SHALL never exceed N-1 and does not wrap within a frame.

Reset
REQ-032 rst=1 at a clock edge SHALL force IDLE from any state, including mid-frame.
- All outputs (in_ready, busy, done, gt_a, gt_b, max_val, max_idx) SHALL be 0.
- cnt and the hold register SHALL be 0.
- A partial frame is discarded with no done pulse.
REQ-033 rst SHALL take priority over start and in_valid in the same cycle.

Configuration
REQ-034 Macro MAX_FINDER_TIE_LAST_EN selects tie handling in CMP.
- Defined: update on gt_f=1 or hold==current max, so the last equal sample wins.
- Undefined: update only on gt_f=1, so the first equal sample wins.

Verification (N=4, W=2; the bench instantiates greater_than on gt_a/gt_b/gt_f)
REQ-035 Frame 1,3,2,0 -> done pulse; max_val=3, max_idx=1; busy falls the cycle after done.
REQ-036 Frame 2,2,1,2:
- Macro undefined -> max_val=2, max_idx=0.
- Macro defined -> max_val=2, max_idx=3.
REQ-037 Frame 0,0,0,3 with continuous in_valid -> max_idx=3; done exactly 8 cycles after the start cycle.
REQ-038 start pulsed again during a frame of 3,1,1,1 -> ignored; result max_val=3, max_idx=0; exactly one done.
REQ-039 rst asserted after 2 samples of a frame -> next cycle: all outputs 0, state IDLE, no done.
- A new frame 1,0,0,2 then yields max_val=2, max_idx=3.
REQ-040 in_valid gaps of 3 cycles between samples of 0,1,2,3 -> in_ready=0 during every CMP; result max_val=3, max_idx=3.
